// File: rtl/io_trace_capture.sv
// Pin-activity recorder: logs every change on N_CH channels into a DEPTH-entry FIFO
// with a registered valid/ready head. Define TRACE_TS_EN to add a saturating delta timestamp.
`timescale 1ns/1ps
module io_trace_capture #(
   parameter int unsigned CH_W  = 8,
   parameter int unsigned N_CH  = 3,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TS_W  = 8,
   localparam int unsigned SW   = N_CH * CH_W,
`ifdef TRACE_TS_EN
   localparam int unsigned DW   = SW + TS_W,
`else
   localparam int unsigned DW   = SW,
`endif
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          arm,
   input  logic [SW-1:0] trig_mask,
   input  logic [SW-1:0] sample_in,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic [LW-1:0] level,
   output logic [1:0]    state,
   output logic          overflow
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_param_check
      $error("io_trace_capture: DEPTH must be a power of two >= 2 and TS_W >= 1");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [SW-1:0]   r_prev;
   logic [DW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]   r_level;
   logic            r_rd_valid;
   logic [DW-1:0]   r_rd_data;
   logic            r_overflow;

   logic            w_change, w_trig, w_pop, w_room, w_push, w_drop, w_head_ok;
   logic [AW-1:0]   w_head_ptr;
   logic [DW-1:0]   w_wdata;

   assign w_change   = ena & (sample_in != r_prev);
   assign w_trig     = ena & |((sample_in ^ r_prev) & trig_mask);
   assign w_pop      = r_rd_valid & rd_ready & ~arm;
   assign w_room     = (r_level != LW'(DEPTH)) | w_pop;
   // The head register is reloaded from storage as it stands before this edge's push,
   // which gives the one-cycle push-to-visible latency and keeps pop/valid consistent.
   assign w_head_ok  = w_pop ? (r_level > LW'(1)) : (r_level != '0);
   assign w_head_ptr = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

`ifdef TRACE_TS_EN
   logic [TS_W-1:0] r_ts;

   assign w_wdata = {r_ts, sample_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts <= '0;
      end else if (arm) begin
         r_ts <= '0;
      end else if (w_push) begin
         r_ts <= TS_W'(1);
      end else if (r_state == CAPTURE && ena && r_ts != '1) begin
         r_ts <= r_ts + TS_W'(1);
      end
   end
`else
   assign w_wdata = sample_in;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_drop      = 1'b0;
      unique case (r_state)
         IDLE: ;
         ARMED: begin
            if (w_trig) begin
               w_push      = w_room;
               w_drop      = ~w_room;
               w_state_nxt = w_room ? CAPTURE : DONE;
            end
         end
         CAPTURE: begin
            if (w_change) begin
               w_push      = w_room;
               w_drop      = ~w_room;
               w_state_nxt = w_room ? CAPTURE : DONE;
            end
         end
         DONE: ;
         default: w_state_nxt = IDLE;
      endcase
      if (arm) begin
         w_state_nxt = ARMED;
         w_push      = 1'b0;
         w_drop      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_prev  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (arm || ena) begin
            r_prev <= sample_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_overflow <= 1'b0;
      end else if (arm) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_rd_valid <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         r_rd_valid <= w_head_ok;
         if (w_head_ok) begin
            r_rd_data <= r_mem[w_head_ptr];
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign level    = r_level;
   assign state    = r_state;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_io_trace_capture.sv
// Scoreboard bench for io_trace_capture: stimulus pushes expected entries, a negedge
// monitor pops and compares each entry the DUT hands over (ts checked with TRACE_TS_EN).
`timescale 1ns/1ps
module tb_io_trace_capture;

   localparam int unsigned CH_W  = 8;
   localparam int unsigned N_CH  = 3;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TS_W  = 8;
   localparam int unsigned SW    = N_CH * CH_W;
`ifdef TRACE_TS_EN
   localparam int unsigned DW    = SW + TS_W;
`else
   localparam int unsigned DW    = SW;
`endif
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n, ena, arm, rd_ready;
   logic [SW-1:0] trig_mask, sample_in;
   logic          rd_valid, overflow;
   logic [DW-1:0] rd_data;
   logic [LW-1:0] level;
   logic [1:0]    state;

   int n_pass  = 0;
   int n_total = 0;
   int n_popped = 0;
   logic [TS_W+SW-1:0] exp_q[$];

   io_trace_capture #(.CH_W(CH_W), .N_CH(N_CH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .arm(arm), .trig_mask(trig_mask),
      .sample_in(sample_in), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .level(level), .state(state), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic chk_entry(input string nm, input logic [TS_W+SW-1:0] e);
`ifdef TRACE_TS_EN
      chk(nm, 64'(rd_data), 64'(e));
`else
      chk(nm, 64'(rd_data), 64'(e[SW-1:0]));
`endif
   endtask

   function automatic logic [TS_W+SW-1:0] ent(input int ts, input logic [SW-1:0] s);
      return {TS_W'(ts), s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      rd_ready = 1'b1;
      while (rd_valid && n < 100) begin
         step();
         n++;
      end
      chk(nm, 64'(rd_valid), 64'(0));
      rd_ready = 1'b0;
   endtask

   // A pop happens at the next rising edge whenever these hold mid-cycle.
   always @(negedge clk) begin
      if (rst_n && rd_valid && rd_ready && !arm) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: got %0h expected no entry at %0t", rd_data, $time);
         end else begin
            chk_entry("sb_entry", exp_q.pop_front());
            n_popped++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int max_lvl;
      int base;
      rst_n = 1'b0; ena = 1'b1; arm = 1'b0; rd_ready = 1'b0;
      trig_mask = '0; sample_in = '0;
      repeat (3) step();
      chk("rst_level", 64'(level), 0);
      chk("rst_valid", 64'(rd_valid), 0);
      chk("rst_state", 64'(state), 0);
      chk("rst_ovf", 64'(overflow), 0);
      chk("rst_data", 64'(rd_data), 0);
      rst_n = 1'b1;

      // idle: toggling inputs never record
      for (int i = 0; i < 4; i++) begin
         sample_in = sample_in ^ 24'hA5A5A5;
         step();
      end
      chk("idle_level", 64'(level), 0);
      chk("idle_valid", 64'(rd_valid), 0);
      chk("idle_state", 64'(state), 0);

      // arm, unmasked changes ignored, channel 0 triggers
      sample_in = '0; trig_mask = 24'h0000FF; arm = 1'b1;
      step();
      arm = 1'b0;
      chk("arm_state", 64'(state), 1);
      sample_in = 24'h00AB00; step();
      sample_in = 24'h000000; step();
      chk("unmasked_state", 64'(state), 1);
      chk("unmasked_level", 64'(level), 0);
      sample_in = 24'h00005A; exp_q.push_back(ent(0, 24'h00005A));
      step();
      chk("trig_state", 64'(state), 2);
      chk("trig_level", 64'(level), 1);
      chk("trig_valid_lat", 64'(rd_valid), 0);
      step();
      chk("trig_valid", 64'(rd_valid), 1);
      chk_entry("trig_head", ent(0, 24'h00005A));

      // deltas: 3 enabled cycles, then 7 enabled cycles around one ena=0 cycle
      step();
      sample_in = 24'h00005B; exp_q.push_back(ent(3, 24'h00005B)); step();
      repeat (3) step();
      ena = 1'b0; step(); ena = 1'b1;
      repeat (3) step();
      sample_in = 24'h00005C; exp_q.push_back(ent(7, 24'h00005C)); step();
      repeat (300) step();
      sample_in = 24'h00005D; exp_q.push_back(ent(255, 24'h00005D)); step();
      step();
      chk("ts_level", 64'(level), 4);
      drain("ts_drain");
      chk("ts_sb_empty", 64'(exp_q.size()), 0);

      // fill to DEPTH, then one dropped change
      sample_in = '0; arm = 1'b1; step(); arm = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         sample_in = SW'(i);
         exp_q.push_back(ent(i == 1 ? 0 : 1, SW'(i)));
         step();
      end
      chk("full_level", 64'(level), 16);
      chk("full_ovf", 64'(overflow), 0);
      chk("full_state", 64'(state), 2);
      sample_in = 24'h000011; step();
      chk("ovf_flag", 64'(overflow), 1);
      chk("ovf_state", 64'(state), 3);
      chk("ovf_level", 64'(level), 16);
      sample_in = 24'h000012; step();
      chk("done_no_push", 64'(level), 16);
      drain("ovf_drain");
      chk("done_state", 64'(state), 3);
      chk("done_level", 64'(level), 0);
      chk("ovf_sb_empty", 64'(exp_q.size()), 0);

      // streaming: a change every cycle with the consumer always ready
      sample_in = '0; arm = 1'b1; step(); arm = 1'b0;
      chk("rearm_ovf", 64'(overflow), 0);
      chk("rearm_state", 64'(state), 1);
      rd_ready = 1'b1;
      base = n_popped;
      max_lvl = 0;
      for (int i = 0; i < 40; i++) begin
         sample_in = 24'hC30000 | SW'(i + 1);
         exp_q.push_back(ent(i == 0 ? 0 : 1, sample_in));
         step();
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      chk("stream_maxlvl_le2", 64'(max_lvl <= 2), 1);
      drain("stream_drain");
      chk("stream_count", 64'(n_popped - base), 40);
      chk("stream_ovf", 64'(overflow), 0);
      chk("stream_state", 64'(state), 2);

      // async reset with entries pending
      for (int i = 0; i < 5; i++) begin
         sample_in = 24'hC30000 | SW'(41 + i);
         step();
      end
      chk("pre_rst_level", 64'(level), 5);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("async_level", 64'(level), 0);
      chk("async_valid", 64'(rd_valid), 0);
      chk("async_state", 64'(state), 0);
      #3 rst_n = 1'b1;
      step();

      // arm wins over a same-cycle pop and push
      sample_in = '0; arm = 1'b1; step(); arm = 1'b0;
      sample_in = 24'h000001; step();
      sample_in = 24'h000002; step();
      step();
      chk("pre_arm_valid", 64'(rd_valid), 1);
      chk("pre_arm_level", 64'(level), 2);
      arm = 1'b1; rd_ready = 1'b1; sample_in = 24'h000003;
      step();
      arm = 1'b0; rd_ready = 1'b0;
      chk("arm_flush_level", 64'(level), 0);
      chk("arm_flush_valid", 64'(rd_valid), 0);
      chk("arm_flush_state", 64'(state), 1);
      step();
      chk("arm_hold_level", 64'(level), 0);
      chk("arm_hold_valid", 64'(rd_valid), 0);
      chk("final_sb_empty", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/io_trace_capture.md
Name: io_trace_capture

Overview:
- Parametrised, synthesizable pin-activity recorder for the TinyTapeout CPU harness; supersedes the plain pin-wiring bench top by adding on-chip observation.
- Watches N_CH channels of CH_W-bit I/O (e.g. uo_out, uio_out, uio_oe) and records every change with a delta timestamp into a DEPTH-entry FIFO.
- A trigger mask starts capture. Entries drain through a valid/ready read port, so cocotb or a UART bridge can read activity without a VCD.

Parameters:
- CH_W, 8, bits per channel.
- N_CH, 3, number of channels; sample width SW = N_CH*CH_W.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- TS_W, 8, delta-timestamp width (used only with TRACE_TS_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  sampling enable; low freezes sampling and the timestamp; the read port stays live.
- arm  in  1  one-cycle pulse: flush and (re)arm; accepted in any state.
- trig_mask  in  SW  bits whose change fires the trigger.
- sample_in  in  SW  concatenated channel inputs, channel 0 in LSBs.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts the head entry.
- rd_data  out  SW+TS_W (SW without TRACE_TS_EN)  head entry {delta_ts, sample}.
- level  out  $clog2(DEPTH)+1  entries stored.
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- overflow  out  1  sticky: a change was dropped.

Behaviour:
- Reset values: state=IDLE, FIFO empty, level=0, rd_valid=0, rd_data=0, overflow=0, prev_q=0, ts counter=0.
- prev_q <= sample_in on every cycle with ena=1, in all states. change = ena & (sample_in != prev_q).
- IDLE: no pushes. arm -> ARMED.
- arm, any state: FIFO flushed, overflow=0, ts=0, prev_q <= sample_in, next state ARMED. A pop in the same cycle is ignored.
- ARMED: if ena & |((sample_in ^ prev_q) & trig_mask), push {0, sample_in} -> CAPTURE. Unmasked changes are ignored.
- CAPTURE: on each change, push {ts, sample_in} and set ts=1. Otherwise, if ena, ts = min(ts+1, 2^TS_W-1) (saturating).
- Push is allowed when level<DEPTH, or when level==DEPTH with a pop in the same cycle.
- Change with FIFO full and no pop: entry dropped, overflow=1, -> DONE.
- DONE: no pushes; reads continue; exit only via arm.
- FIFO ordering and timing:
  - First-word ordering.
  - Registered head: rd_data and rd_valid update 1 cycle after the push edge.
  - Pop on rd_valid & rd_ready.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
  - rd_data holds its value while rd_valid & !rd_ready.
- Pop when empty: no effect.
- level is always 0..DEPTH and never wraps.
- Async reset mid-capture: everything returns to reset values immediately; a partial entry is never visible.

Optional Feature:
- Macro: TRACE_TS_EN.
- Defined: the timestamp counter is present and rd_data is SW+TS_W bits, {delta_ts, sample}.
- Undefined: no counter logic; rd_data is SW bits, sample only; FIFO width shrinks to SW; all other behaviour is identical.

Test Plan:
- Reset then idle, sample_in toggling: level=0, rd_valid=0, state=0.
- arm; trig_mask=0x0000FF; change bits 8..15 only -> state stays 1, no entry. Then channel 0 changes 0x00->0x5A -> state=2, head {ts=0, 0x00005A} valid 1 cycle later.
- In CAPTURE, changes 3 then 7 enabled cycles after the previous entry, with one ena=0 cycle in the second gap -> ts=3 then ts=7. With TS_W=4, a gap of 20 cycles -> ts=15.
- rd_ready=0; 16 changes -> level=16; 17th change -> overflow=1, state=3. Then drain 16 entries in order -> rd_valid=0, state stays 3.
- rd_ready held 1, one change per cycle for 40 cycles (full and pop coinciding) -> no overflow, 40 entries read in order, level<=2.
- Assert rst_n=0 mid-capture with level=5 -> level=0, rd_valid=0, state=0 asynchronously. arm, FIFO pop and the same-cycle push vs arm -> FIFO empty, state=1.
